// File: rtl/instr_fetch_queue.sv
// Decoupling FIFO between the instruction re-aligner and decode. Each entry holds instr, PC and a compressed flag.
// Optional macro INSTR_FETCH_QUEUE_BYPASS_EN adds a zero-latency path from input to output when the queue is empty.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [XLEN-1:0]            instr_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [XLEN-1:0]            instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       is_compressed_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [DEPTH-1:0] mem_c_q;

  logic empty, full;
  logic wr_en, rd_en;
  logic in_compressed;
  logic bypass;

  assign empty         = (count_q == '0);
  assign full          = (count_q == CW'(DEPTH));
  assign in_compressed = (instr_i[1:0] != 2'b11);

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed by decode in the same cycle never occupies a slot.
  assign wr_en = valid_i & ~full & ~flush_i & ~(bypass & ready_i);
  assign rd_en = ~empty & ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_instr_q[wr_ptr_q] <= instr_i;
      mem_pc_q[wr_ptr_q]    <= pc_i;
      mem_c_q[wr_ptr_q]     <= in_compressed;
    end
  end

  always_comb begin
    ready_o         = ~full;
    count_o         = count_q;
    valid_o         = ~empty;
    instr_o         = NOP;
    pc_o            = '0;
    is_compressed_o = 1'b0;
    if (!empty) begin
      instr_o         = mem_instr_q[rd_ptr_q];
      pc_o            = mem_pc_q[rd_ptr_q];
      is_compressed_o = mem_c_q[rd_ptr_q];
    end
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      valid_o         = 1'b1;
      instr_o         = instr_i;
      pc_o            = pc_i;
      is_compressed_o = in_compressed;
    end
`endif
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue; expected entries are queued on accepted pushes and checked at the head.
// Honours INSTR_FETCH_QUEUE_BYPASS_EN for the zero-latency path.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, valid_i, ready_i;
  logic [31:0] instr_i, pc_i;
  logic        ready_o, valid_o, is_compressed_o;
  logic [31:0] instr_o, pc_o;
  logic [2:0]  count_o;

  entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .ready_o(ready_o),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .is_compressed_o(is_compressed_o), .ready_i(ready_i), .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs at the falling edge, update the scoreboard, advance past the rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    entry_t in_e, head;
    logic   exp_valid, exp_ready, byp_now, push, pop;
    valid_i = v; instr_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
    in_e.instr = ins; in_e.pc = pc; in_e.c = (ins[1:0] != 2'b11);
    @(negedge clk_i);
    byp_now   = BYP && v && !fl && (sb.size() == 0);
    exp_ready = (sb.size() != DEPTH);
    exp_valid = (sb.size() != 0) || byp_now;
    chk("count_o", 32'(count_o), 32'(sb.size()));
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("valid_o", 32'(valid_o), 32'(exp_valid));
    if (sb.size() != 0) head = sb[0];
    else if (byp_now)   head = in_e;
    else begin
      head.instr = NOP; head.pc = '0; head.c = 1'b0;
    end
    chk("instr_o", instr_o, head.instr);
    chk("pc_o", pc_o, head.pc);
    chk("is_compressed_o", 32'(is_compressed_o), 32'(head.c));
    if (fl) begin
      sb.delete();
    end else begin
      push = v && exp_ready;
      pop  = exp_valid && rdy;
      if (push) sb.push_back(in_e);
      if (pop) void'(sb.pop_front());
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] nxt_pc;
    rst_ni = 1'b0; flush_i = 0; valid_i = 0; ready_i = 0; instr_i = '0; pc_i = '0;
    #12;
    chk("rst valid_o", 32'(valid_o), 0);
    chk("rst ready_o", 32'(ready_o), 1);
    chk("rst count_o", 32'(count_o), 0);
    chk("rst instr_o", instr_o, NOP);
    chk("rst pc_o", pc_o, 0);
    chk("rst is_compressed_o", 32'(is_compressed_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Fill to full, then a refused fifth push
    for (int k = 0; k < 4; k++) cycle(1, 32'h93 + 32'(4*k), 32'h100 + 32'(4*k), 0, 0);
    cycle(1, 32'hdead_beef, 32'h110, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("full count", 32'(count_o), 4);

    // Drain in order
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("drained valid_o", 32'(valid_o), 0);

    // Compressed then full-width instruction
    cycle(1, 32'h0000_4501, 32'h200, 0, 0);
    cycle(1, 32'h00A0_0513, 32'h202, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Steady push+pop at count 2, pointers wrap
    cycle(1, 32'h0000_1001, 32'h300, 0, 0);
    cycle(1, 32'h0000_1003, 32'h304, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, 32'h2003 + 32'(k << 4), 32'h308 + 32'(4*k), 1, 0);
    chk("steady count", 32'(count_o), 2);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Flush with 3 entries and a concurrent push
    for (int k = 0; k < 3; k++) cycle(1, 32'h4003 + 32'(k << 4), 32'h400 + 32'(4*k), 0, 0);
    cycle(1, 32'h5555_5557, 32'h500, 1, 1);
    cycle(0, 0, 0, 1, 0);
    chk("post-flush count", 32'(count_o), 0);

    // Asynchronous reset between edges
    cycle(1, 32'h6003, 32'h600, 0, 0);
    cycle(1, 32'h6013, 32'h604, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("async rst valid_o", 32'(valid_o), 0);
    chk("async rst count_o", 32'(count_o), 0);
    chk("async rst instr_o", instr_o, NOP);
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Empty queue, push with decode ready
    cycle(1, 32'h0000_7013, 32'h700, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Random traffic with occasional flush
    nxt_pc = 32'h1000;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      r = $urandom;
      cycle(r[0] | r[1], {r[31:4], 2'b00, r[2], r[3]}, nxt_pc, r[5] | r[6], (r[11:7] == 5'd0));
      nxt_pc += 4;
    end
    while (sb.size() != 0 && n_checks < 100000) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Decoupling FIFO directly downstream of the instruction re-aligner. Sits between the re-aligner output and the decode stage.
- Captures each re-aligned instruction word together with its PC and a compressed flag, then presents them to decode under a valid/ready handshake.
- Absorbs decode back-pressure so the fetch side is stalled only when the queue is full. Drops all contents on a controller flush.

Parameters:
- DEPTH, 4: number of entries. Power of two, ≥2.
- XLEN, 32: width of instruction and PC fields.

Ports:
- clk_i  in  1  subsystem clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  controller fetch flush; synchronous clear.
- valid_i  in  1  re-aligner presents a valid instruction.
- instr_i  in  XLEN  re-aligned instruction; compressed form occupies [15:0].
- pc_i  in  XLEN  PC of instr_i.
- ready_o  out  1  queue accepts a push this cycle.
- valid_o  out  1  head entry valid for decode.
- instr_o  out  XLEN  head instruction.
- pc_o  out  XLEN  head PC.
- is_compressed_o  out  1  head instruction is 16-bit.
- ready_i  in  1  decode consumes the head this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_ni=0, asynchronous): rd/wr pointers=0, count=0.
  - valid_o=0, ready_o=1, count_o=0.
  - instr_o=32'h0000_0013 (NOP), pc_o=0, is_compressed_o=0.
- Handshakes:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
  - ready_o = (count != DEPTH); it has no combinational dependency on ready_i.
- Compressed flag: computed at push as (instr_i[1:0] != 2'b11) and stored with the entry. instr_i and pc_i are stored unmodified.
- Latency: a pushed entry appears on the outputs the cycle after the push edge (1-cycle latency).
- Outputs:
  - Driven from the head entry (rd pointer); valid_o = (count != 0).
  - When empty: instr_o=NOP, pc_o=0, is_compressed_o=0, independent of stale storage.
- Pointers:
  - Increment by 1 mod DEPTH; wrap from DEPTH-1 to 0.
  - count +1 on push only, -1 on pop only, unchanged on push+pop.
- Full (count=DEPTH): ready_o=0, so no push is taken even if a pop occurs the same cycle. The freed slot is visible the next cycle.
- Empty (count=0): valid_o=0, so no pop is taken. A push in this cycle is written normally.
- Simultaneous push and pop with 0<count<DEPTH: both take effect; count is unchanged; FIFO order is preserved.
- Flush:
  - flush_i=1 at an edge: pointers=0, count=0. Any same-cycle push or pop is ignored.
  - Next cycle: valid_o=0, ready_o=1.
  - Flush has priority over push and pop.
- Reset mid-operation: all contents are lost immediately. The outputs take their reset values without waiting for a clock edge.
- Storage array needs no reset.

Optional Feature:
- Macro INSTR_FETCH_QUEUE_BYPASS_EN.
- Defined, when count=0 and valid_i=1 and flush_i=0:
  - valid_o=1 combinationally.
  - instr_o=instr_i, pc_o=pc_i, is_compressed_o from instr_i.
  - If ready_i=1, the instruction is consumed directly and not written (count stays 0).
  - If ready_i=0, it is written normally.
  - Gives 0-cycle latency on an empty queue.
- Not defined: no combinational path from input to output; always 1-cycle latency.

Test Plan:
- Reset, then push 4 words (instr 32'h0000_0093+4k, pc 32'h100+4k), ready_i=0 → count_o=4, ready_o=0. A 5th push is refused, count stays 4.
- From full, ready_i=1 for 4 cycles → outputs in order pc 0x100,0x104,0x108,0x10C; valid_o drops after the 4th pop; instr_o=NOP.
- Push 16'h4501 (c.li) at pc 0x200, then 32'h00A00513 at pc 0x202 → is_compressed_o=1 then 0; pc_o=0x200 then 0x202.
- Keep count=2; push+pop every cycle for 10 cycles, so pointers wrap twice → count_o stays 2; output order matches input order.
- Queue holds 3 entries; flush_i=1 with valid_i=1 → next cycle count_o=0, valid_o=0, ready_o=1; the pushed word never appears.
- Assert rst_ni=0 mid-stream between edges → valid_o=0 and count_o=0 immediately. With INSTR_FETCH_QUEUE_BYPASS_EN and queue empty: valid_i=1, ready_i=1 → valid_o=1 the same cycle, count stays 0.
